// File: rtl/rf_wb_sched.sv
// rf_wb_sched: writeback scheduler in front of a 32x32 register file with
// a single write port and asynchronous read.
//   - Keeps a 32-entry busy scoreboard of pending destination writes and
//     stalls issue on RAW/WAW hazards.
//   - Round-robin arbitrates NREQ writeback requesters onto the write port.
//   - Drives the file's write port from a registered output stage.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   issue_*_i               instruction presented for issue
//   issue_stall_o           combinational: issue not accepted this cycle
//   wb_valid_i/addr_i/data_i  per-requester writeback requests (flattened)
//   wb_ready_o              combinational one-hot grant
//   w_en_o/w_addr_o/w_data_o  registered register-file write port
//   busy_o                  scoreboard (bit 0 always 0)
//   spurious_wb_o           sticky: a writeback hit a non-busy register
module rf_wb_sched #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rs1_i,
  input  logic [4:0]           issue_rs2_i,
  input  logic                 issue_uses_rs1_i,
  input  logic                 issue_uses_rs2_i,
  input  logic                 issue_writes_rd_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 issue_stall_o,
  input  logic [NREQ-1:0]      wb_valid_i,
  input  logic [5*NREQ-1:0]    wb_addr_i,
  input  logic [XLEN*NREQ-1:0] wb_data_i,
  output logic [NREQ-1:0]      wb_ready_o,
  output logic                 w_en_o,
  output logic [4:0]           w_addr_o,
  output logic [XLEN-1:0]      w_data_o,
  output logic [31:0]          busy_o,
  output logic                 spurious_wb_o
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [31:0]     busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            w_en_q, w_en_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic            spurious_q, spurious_d;

  logic            stall_s;
  logic            accept_s;
  logic [NREQ-1:0] grant_s;
  logic            hs_s;
  int              idx_s;
  int              gidx_s;
  logic [4:0]      sel_addr_s;
  logic [XLEN-1:0] sel_data_s;

  // Hazard check against the current scoreboard; busy bit 0 is never set,
  // so x0 operands never stall.
  always_comb begin
    stall_s  = issue_valid_i &
               ((issue_uses_rs1_i  & busy_q[issue_rs1_i]) |
                (issue_uses_rs2_i  & busy_q[issue_rs2_i]) |
                (issue_writes_rd_i & busy_q[issue_rd_i]));
    accept_s = issue_valid_i & ~stall_s;
  end

  // Round-robin scan starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_s = '0;
    hs_s    = 1'b0;
    gidx_s  = 0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr_q) + k) % NREQ;
      if (!hs_s && wb_valid_i[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        hs_s           = 1'b1;
        gidx_s         = idx_s;
      end else begin
        hs_s = hs_s;
      end
    end
    sel_addr_s = wb_addr_i[5*gidx_s +: 5];
    sel_data_s = wb_data_i[XLEN*gidx_s +: XLEN];
  end

  // Next-state for scoreboard, pointer, write stage and spurious flag.
  always_comb begin
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    spurious_d = spurious_q;
    // Clear on the register-file write edge; applied before the set so
    // that a same-register set and clear resolves to set.
    if (w_en_q) begin
      busy_d[w_addr_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (accept_s && issue_writes_rd_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    if (hs_s) begin
      ptr_d = PW'((gidx_s + 1) % NREQ);
      // Address 0 is consumed without a write or scoreboard effect.
      if (sel_addr_s != 5'd0) begin
        w_en_d   = 1'b1;
        w_addr_d = sel_addr_s;
        w_data_d = sel_data_s;
        if (!busy_q[sel_addr_s]) begin
          spurious_d = 1'b1;
        end else begin
          spurious_d = spurious_q;
        end
      end else begin
        w_en_d = 1'b0;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q     <= 32'd0;
      ptr_q      <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= 5'd0;
      w_data_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      spurious_q <= spurious_d;
    end
  end

  assign issue_stall_o = stall_s;
  assign wb_ready_o    = grant_s;
  assign w_en_o        = w_en_q;
  assign w_addr_o      = w_addr_q;
  assign w_data_o      = w_data_q;
  assign busy_o        = busy_q;
  assign spurious_wb_o = spurious_q;

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Sits between the pipeline and the 32x32 register file (single write port, asynchronous read).
- Holds a 32-entry busy scoreboard of pending destination writes and stalls issue on RAW/WAW hazards.
- Round-robin arbitrates NREQ writeback requesters onto the one write port.
- Drives the file's write-address, write-data and write-enable inputs from a registered output stage.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ISSUE_VALID  in  1  instruction presented for issue.
- ISSUE_RS1  in  5  source 1 address.
- ISSUE_RS2  in  5  source 2 address.
- ISSUE_USES_RS1  in  1  source 1 is read.
- ISSUE_USES_RS2  in  1  source 2 is read.
- ISSUE_WRITES_RD  in  1  instruction writes a destination.
- ISSUE_RD  in  5  destination address.
- ISSUE_STALL  out  1  combinational; issue is not accepted this cycle.
- WB_VALID  in  NREQ  per-requester writeback request.
- WB_ADDR  in  5*NREQ  flattened destination addresses; requester i uses bits [5i+4:5i].
- WB_DATA  in  XLEN*NREQ  flattened write data.
- WB_READY  out  NREQ  combinational one-hot grant.
- W_EN  out  1  registered write enable to the register file.
- W_ADDR  out  5  registered write address.
- W_DATA  out  XLEN  registered write data.
- BUSY  out  32  scoreboard; bit 0 is always 0.
- SPURIOUS_WB  out  1  sticky flag: a writeback targeted a non-busy register.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - BUSY=0, W_EN=0, W_ADDR=0, W_DATA=0, SPURIOUS_WB=0, round-robin pointer=0.
  - State is held while RST_N is low.
  - Reset mid-operation drops every pending busy bit and any staged write; nothing is written after reset.
- Hazard check (combinational):
  - ISSUE_STALL = ISSUE_VALID & (uses_rs1 & BUSY[rs1] | uses_rs2 & BUSY[rs2] | writes_rd & BUSY[rd]).
  - Because BUSY[0] is always 0, x0 never stalls.
- Issue accept:
  - Accept = ISSUE_VALID & !ISSUE_STALL.
  - If accepted, ISSUE_WRITES_RD=1 and rd!=0, set BUSY[rd] at the next edge.
- Arbitration (combinational):
  - Start at the pointer and scan upward, wrapping modulo NREQ; the first asserted WB_VALID gets WB_READY.
  - At most one WB_READY is high; WB_READY=0 when no request is valid.
  - A handshake occurs when WB_VALID[i] & WB_READY[i].
  - After a handshake by requester i, pointer <= (i+1) mod NREQ. With no handshake the pointer holds.
  - A requester keeps WB_VALID, WB_ADDR and WB_DATA stable until granted.
- Write stage (1-cycle latency):
  - On the edge after a handshake with addr!=0: W_EN=1, W_ADDR=addr, W_DATA=data.
  - Otherwise W_EN=0 and W_ADDR/W_DATA hold their last values.
  - A handshake with addr=0 is accepted and consumed: no write, no busy change.
  - The pipeline sustains one write per cycle.
- Busy clear:
  - While W_EN=1, the edge that ends that cycle (the register file write edge) clears BUSY[W_ADDR].
  - The stall is therefore held through the W_EN cycle and released the following cycle, when the file holds the new value. There is no bypass.
- Set and clear on the same edge for the same register: set wins. This arises only from the busy-reissue corner and is unreachable under the WAW stall, but it must still be implemented.
- Set and clear on the same edge for different registers: both take effect.
- Spurious writeback:
  - A handshake with addr!=0 while BUSY[addr]=0 sets SPURIOUS_WB=1 (sticky until reset).
  - The write is still performed.
- Latency summary:
  - WB handshake at edge N → W_EN high during cycle N+1 → BUSY clear and stall drop visible in cycle N+2.

Test Plan:
- Reset, then issue rd=5 (writes_rd=1) → BUSY=0x0000_0020 next cycle. Issue with rs1=5 → ISSUE_STALL=1.
- With BUSY[5] set, requester 0 writes back addr=5, data=0xDEADBEEF:
  - WB_READY[0]=1.
  - Next cycle W_EN=1, W_ADDR=5, W_DATA=0xDEADBEEF, stall still 1.
  - The cycle after: BUSY[5]=0, stall=0.
- BUSY[3] and BUSY[7] set; both requesters valid continuously (req0 addr=3, req1 addr=7):
  - Grants go 0 then 1 on back-to-back cycles.
  - W_ADDR sequence is 3, 7 with W_EN high two consecutive cycles.
  - A fresh pair of requests then starts from req0.
- Writeback addr=0 → WB_READY asserted, W_EN stays 0, BUSY unchanged, SPURIOUS_WB=0.
- Writeback addr=9 with BUSY[9]=0 → W_EN=1 and W_ADDR=9 next cycle; SPURIOUS_WB=1, and it stays 1 after a valid writeback.
- Set BUSY[4], stage a writeback to 4, assert RST_N=0 asynchronously mid-cycle → immediately BUSY=0, W_EN=0, SPURIOUS_WB=0. After release, no write to 4 occurs.
